// File: rtl/string_scroller.sv
// Character-ROM sequencer: scrolls a word right-to-left through a DIGITS-wide window
// and time-multiplexes that window onto a digit-select/code display bus. SCROLL_LOOP_EN repeats passes.
module string_scroller #(
    parameter int         DIGITS   = 4,
    parameter int         PRESCALE = 25000000,
    parameter int         SCAN_DIV = 50000,
    parameter logic [3:0] BLANK    = 4'b1111
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  enable,
    input  logic [3:0]            caracter,
    input  logic [3:0]            len_string,
    output logic [3:0]            counter_caracter,
    output logic [4*DIGITS-1:0]   window,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [3:0]            digit_code
);

    localparam int PW = $clog2(PRESCALE);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [4*DIGITS-1:0] ALL_BLANK = {DIGITS{BLANK}};

    typedef enum logic [1:0] {IDLE, SCROLL, DRAIN} state_t;

    state_t              r_state;
    logic [PW-1:0]       r_prescaler;
    logic [IW-1:0]       r_drain_cnt;
    logic [3:0]          r_cnt;
    logic [4*DIGITS-1:0] r_window;
    logic                r_busy;
    logic                r_done;
    logic [SW-1:0]       r_scan_cnt;
    logic [IW-1:0]       r_scan_idx;
    logic [DIGITS-1:0]   r_digit_sel;
    logic [3:0]          r_digit_code;

    logic w_tick;
    logic w_scan_adv;

    assign w_tick     = r_busy && enable && (r_prescaler == PW'(PRESCALE - 1));
    assign w_scan_adv = (r_scan_cnt == SW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_prescaler <= '0;
            r_drain_cnt <= '0;
            r_cnt       <= '0;
            r_window    <= ALL_BLANK;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Prescaler only runs during a pass and freezes with enable low.
            if (r_busy && enable)
                r_prescaler <= w_tick ? '0 : r_prescaler + PW'(1);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= SCROLL;
                        r_cnt       <= '0;
                        r_prescaler <= '0;
                        r_window    <= ALL_BLANK;
                        r_busy      <= 1'b1;
                    end
                end
                SCROLL: begin
                    if (w_tick) begin
                        r_window <= {r_window[4*DIGITS-5:0], caracter};
                        if (r_cnt == len_string) begin
                            r_cnt       <= '0;
                            r_drain_cnt <= '0;
                            r_state     <= DRAIN;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_tick) begin
                        r_window <= {r_window[4*DIGITS-5:0], BLANK};
                        if (r_drain_cnt == IW'(DIGITS - 1)) begin
                            r_done  <= 1'b1;
`ifdef SCROLL_LOOP_EN
                            r_state <= SCROLL;
`else
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_drain_cnt <= r_drain_cnt + IW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Display scan is free-running so the display never goes dark while frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_cnt   <= '0;
            r_scan_idx   <= '0;
            r_digit_sel  <= ~DIGITS'(1);
            r_digit_code <= BLANK;
        end else begin
            if (w_scan_adv) begin
                r_scan_cnt <= '0;
                r_scan_idx <= (r_scan_idx == IW'(DIGITS - 1)) ? '0 : r_scan_idx + IW'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + SW'(1);
            end
            r_digit_sel  <= ~(DIGITS'(1) << r_scan_idx);
            r_digit_code <= r_window[{r_scan_idx, 2'b00} +: 4];
        end
    end

    assign counter_caracter = r_cnt;
    assign window           = r_window;
    assign busy             = r_busy;
    assign done             = r_done;
    assign digit_sel        = r_digit_sel;
    assign digit_code       = r_digit_code;

endmodule

// File: doc/string_scroller.md
Name: string_scroller

Overview:
- Sequencer directly downstream of the per-word character ROMs.
- Drives the ROM index `counter_caracter` and reads back `caracter` and `len_string`.
- Scrolls the word right-to-left through a DIGITS-wide window, one character per step tick.
- Time-multiplexes the window onto a common display bus (digit select plus 4-bit code) for the display decoder.

Parameters:
- DIGITS, 4, number of display digits in the window (2..8).
- PRESCALE, 25000000, clk cycles per scroll step (>=2).
- SCAN_DIV, 50000, clk cycles per digit-scan advance (>=1).
- BLANK, 4'b1111, code shifted in for empty positions.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begins a scroll pass; ignored unless IDLE.
- enable  in  1  high = prescaler/FSM advance; low = freeze (scan keeps running).
- caracter  in  4  ROM character code for current counter_caracter (combinational from ROM).
- len_string  in  4  ROM last valid index, inclusive (8 => 9 characters).
- counter_caracter  out  4  registered ROM index.
- window  out  4*DIGITS  window contents; [3:0] rightmost/newest, MSB nibble leftmost/oldest.
- busy  out  1  high in SCROLL or DRAIN.
- done  out  1  1-cycle pulse at end of each pass.
- digit_sel  out  DIGITS  active-low one-hot digit enable.
- digit_code  out  4  window nibble of the currently selected digit.

Behaviour:
- Reset values (async, reset_n low):
  - state=IDLE, counter_caracter=0, window=all BLANK, busy=0, done=0.
  - prescaler=0, scan index=0, digit_sel=~1 (digit 0 low), digit_code=BLANK.
- FSM states: IDLE, SCROLL, DRAIN.
- IDLE:
  - On start: go to SCROLL, counter_caracter=0, prescaler=0, window=all BLANK.
  - busy rises the cycle after start.
- Step tick:
  - Fires when enable=1 and prescaler==PRESCALE-1; prescaler then wraps to 0.
  - prescaler increments only while busy && enable.
  - The first tick occurs PRESCALE enabled cycles after start.
- SCROLL, on tick:
  - window <= {window shifted left one nibble, caracter}.
  - If counter_caracter==len_string: counter_caracter<=0, go to DRAIN with drain count=0.
  - Otherwise counter_caracter increments by 1.
- DRAIN, on tick:
  - window <= {window shifted left one nibble, BLANK}; drain count increments.
  - After the DIGITS-th drain tick: done=1 for exactly the next cycle, busy=0, go to IDLE. Window is then all BLANK.
- Pass length: (len_string+1)+DIGITS ticks.
- Boundaries:
  - len_string=0: a single character scrolls.
  - counter_caracter never exceeds len_string and is 0 throughout DRAIN.
  - start while busy: ignored.
  - enable low mid-pass: all state held, prescaler holds its value.
  - Reset mid-pass: immediate return to reset values; no done pulse.
- Scan:
  - Free-running from reset; independent of FSM and enable.
  - Every SCAN_DIV cycles the scan index advances 0..DIGITS-1 and wraps to 0.
  - digit_sel and digit_code are registered and update together, 1-cycle latency from index change.
  - digit_code = window nibble[index].

Optional Feature:
- Macro: SCROLL_LOOP_EN.
- Defined:
  - After the final DRAIN tick, done pulses, then the FSM re-enters SCROLL with counter_caracter=0. busy stays 1.
  - Passes repeat until reset. start is ignored while looping.
- Undefined: single pass, returns to IDLE as described above.

Test Plan:
- All tests use the REJEITADO ROM: R=9, E=3, J=5, E=3, I=4, T=A, A=0, D=2, O=7, len_string=8. Bench parameters: PRESCALE=2, SCAN_DIV=1, DIGITS=4.
- Reset: reset_n low mid-run -> window=16'hFFFF, counter_caracter=0, busy=0, digit_sel=4'b1110, all immediately.
- Pass: start pulse ->
  - After 4 ticks: window=16'h9353.
  - After 9 ticks: window=16'hA027 and counter_caracter=0, state DRAIN.
  - After 13 ticks: window=16'hFFFF, one done pulse, busy=0.
- Freeze: enable low for 10 cycles after the 2nd tick -> window stays 16'hFF93, counter_caracter stays 2; the pass then resumes and completes identically.
- Ignored start: start re-pulsed while busy -> no restart, exactly one done per pass.
- Scan: window=16'h9353 held -> digit_sel cycles 1110,1101,1011,0111 with digit_code 3,5,3,9.
- Loop (SCROLL_LOOP_EN defined): start once -> done pulses every 26 cycles; busy never falls; 2nd pass window after 4 ticks = 16'h9353.
